// File: rtl/seq_detect_ctrl_if.sv
// Front-end and detector-side signals of the 1011 detector sequencer.
// The master side is the register front end plus the detector; the slave side is the controller.
interface seq_detect_ctrl_if #(
    parameter int W     = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
);
    logic             start;
    logic [W-1:0]     data_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic             first_valid;
    logic [IDX_W-1:0] first_idx;
    logic             det_x;
    logic             det_rst;
    logic             det_z;

    modport master (
        output start, data_in, det_z,
        input  busy, done, match_cnt, first_valid, first_idx, det_x, det_rst
    );

    modport slave (
        input  start, data_in, det_z,
        output busy, done, match_cnt, first_valid, first_idx, det_x, det_rst
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Sequencer for a serial 1011 detector: clears it, shifts a word in MSB-first, counts match pulses.
// Latency start->done is W+2 cycles; start is only honoured in IDLE (no queuing, no backpressure).
module seq_detect_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_detect_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [W-1:0]     sh_q, sh_d;
    logic [IDX_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic [IDX_W-1:0] fidx_q, fidx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             det_x_q, det_x_d;
    logic             clear_q, clear_d;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        fv_d    = fv_q;
        fidx_d  = fidx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        det_x_d = det_x_q;
        clear_d = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                det_x_d = 1'b0;
                if (bus.start) begin
                    // Results are wiped as the run is accepted so they read zero throughout CLEAR.
                    state_d = CLEAR;
                    sh_d    = bus.data_in;
                    bit_d   = '0;
                    cnt_d   = '0;
                    fv_d    = 1'b0;
                    fidx_d  = '0;
                    busy_d  = 1'b1;
                    clear_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                det_x_d = sh_q[W-1];
            end
            SHIFT: begin
                if (bus.det_z) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fidx_d = bit_q;
                    end
                end
                sh_d  = {sh_q[W-2:0], 1'b0};
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST_BIT) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    det_x_d = 1'b0;
                end else begin
                    // det_x is registered, so present the bit that follows the one on the wire now.
                    det_x_d = sh_q[W-2];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            fidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            det_x_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            fidx_q  <= fidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            det_x_q <= det_x_d;
            clear_q <= clear_d;
        end
    end

    // The detector must also be held clear for as long as the controller itself is in reset.
    assign bus.det_rst     = reset | clear_q;
    assign bus.det_x       = det_x_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match_cnt   = cnt_q;
    assign bus.first_valid = fv_q;
    assign bus.first_idx   = fidx_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl with a behavioural 1011 Mealy detector attached to the detector port.
module tb_seq_detect_ctrl;
    localparam int W = 16;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    seq_detect_ctrl_if #(.W(W), .CNT_W(5), .IDX_W(4)) bus ();

    seq_detect_ctrl #(.W(W), .CNT_W(5), .IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping 1011 Mealy detector: state is the length of the matched prefix.
    logic [1:0] det_state;
    always @(posedge clk or posedge bus.det_rst) begin
        if (bus.det_rst) det_state <= 2'd0;
        else begin
            case (det_state)
                2'd0: det_state <= bus.det_x ? 2'd1 : 2'd0;
                2'd1: det_state <= bus.det_x ? 2'd1 : 2'd2;
                2'd2: det_state <= bus.det_x ? 2'd3 : 2'd0;
                default: det_state <= bus.det_x ? 2'd1 : 2'd2;
            endcase
        end
    end
    assign bus.det_z = (det_state == 2'd3) && bus.det_x;

    // Reference: count every 4-bit window equal to 1011, MSB first.
    function automatic void model(input logic [15:0] w, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 3; i < W; i++) begin
            if (w[18-i -: 4] == 4'b1011) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endfunction

    task automatic run_word(input logic [15:0] w, output int lat, output int busy_n,
                            output logic [4:0] cnt, output logic fv, output logic [3:0] idx,
                            output logic [15:0] bits);
        lat = -1; busy_n = 0; cnt = '0; fv = 1'b0; idx = '0; bits = '0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = w;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = 16'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (c >= 2 && c <= W + 1) bits[W-1-(c-2)] = bus.det_x;
            if (bus.done) begin
                lat = c;
                cnt = bus.match_cnt;
                fv  = bus.first_valid;
                idx = bus.first_idx;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.first_valid, bus.det_x} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got busy/done/fv/det_x=%b exp=0000",
                     {bus.busy, bus.done, bus.first_valid, bus.det_x});
        end
        checks++;
        if (bus.match_cnt !== 5'd0 || bus.first_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_results got cnt=%0d idx=%0d exp 0/0", bus.match_cnt, bus.first_idx);
        end
        checks++;
        if (bus.det_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_det_rst got=%b exp=1", bus.det_rst);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.det_rst !== 1'b0) begin
            failures++;
            $display("FAIL idle_det_rst got=%b exp=0", bus.det_rst);
        end
    endtask

    task automatic test_directed();
        logic [15:0] words [5] = '{16'hB000, 16'hB600, 16'h000B, 16'h0000, 16'hFFFF};
        int lat, busy_n, ecnt, efirst;
        logic [4:0] cnt; logic fv; logic [3:0] idx; logic [15:0] bits;
        foreach (words[k]) begin
            model(words[k], ecnt, efirst);
            run_word(words[k], lat, busy_n, cnt, fv, idx, bits);
            checks++;
            if (lat !== W + 2) begin
                failures++;
                $display("FAIL dir_latency word=%h got=%0d exp=%0d", words[k], lat, W + 2);
            end
            checks++;
            if (cnt !== 5'(ecnt) || fv !== (ecnt > 0)) begin
                failures++;
                $display("FAIL dir_count word=%h got cnt=%0d fv=%b exp cnt=%0d fv=%b",
                         words[k], cnt, fv, ecnt, ecnt > 0);
            end
            checks++;
            if (idx !== 4'((efirst < 0) ? 0 : efirst)) begin
                failures++;
                $display("FAIL dir_first_idx word=%h got=%0d exp=%0d", words[k], idx, efirst);
            end
        end
    endtask

    task automatic test_random();
        int lat, busy_n, ecnt, efirst;
        logic [4:0] cnt; logic fv; logic [3:0] idx; logic [15:0] bits, w;
        for (int r = 0; r < 25; r++) begin
            w = 16'($urandom);
            if (r % 3 == 0) w[12 -: 4] = 4'b1011;
            model(w, ecnt, efirst);
            run_word(w, lat, busy_n, cnt, fv, idx, bits);
            checks++;
            if (lat !== W + 2 || busy_n !== W + 1) begin
                failures++;
                $display("FAIL rnd_timing word=%h got lat=%0d busy=%0d exp lat=%0d busy=%0d",
                         w, lat, busy_n, W + 2, W + 1);
            end
            checks++;
            if (bits !== w) begin
                failures++;
                $display("FAIL rnd_serial word=%h got det_x stream=%h exp=%h", w, bits, w);
            end
            checks++;
            if (cnt !== 5'(ecnt) || fv !== (ecnt > 0) || idx !== 4'((efirst < 0) ? 0 : efirst)) begin
                failures++;
                $display("FAIL rnd_result word=%h got cnt=%0d fv=%b idx=%0d exp cnt=%0d first=%0d",
                         w, cnt, fv, idx, ecnt, efirst);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat = -1, busy_n = 0;
        logic [4:0] cnt = '0; logic [3:0] idx = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 16'hB000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = (c == 5);
            bus.data_in = (c == 5) ? 16'hBBBB : 16'h0000;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = c; cnt = bus.match_cnt; idx = bus.first_idx;
                break;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (lat !== W + 2 || busy_n !== W + 1) begin
            failures++;
            $display("FAIL ign_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", lat, busy_n, W + 2, W + 1);
        end
        checks++;
        if (cnt !== 5'd1 || idx !== 4'd3) begin
            failures++;
            $display("FAIL ign_result got cnt=%0d idx=%0d exp cnt=1 idx=3", cnt, idx);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_no_queue got busy=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, busy_n, dones = 0;
        logic [4:0] cnt; logic fv; logic [3:0] idx; logic [15:0] bits;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 16'hB000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.match_cnt !== 5'd1) begin
            failures++;
            $display("FAIL mid_before got busy=%b cnt=%0d exp busy=1 cnt=1", bus.busy, bus.match_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.match_cnt !== 5'd0 || bus.first_valid !== 1'b0 ||
            bus.det_rst !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort got busy=%b cnt=%0d fv=%b det_rst=%b done=%b exp 0/0/0/1/0",
                     bus.busy, bus.match_cnt, bus.first_valid, bus.det_rst, bus.done);
        end
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL mid_no_done got dones=%0d exp=0", dones);
        end
        run_word(16'hB000, lat, busy_n, cnt, fv, idx, bits);
        checks++;
        if (lat !== W + 2 || cnt !== 5'd1 || fv !== 1'b1 || idx !== 4'd3) begin
            failures++;
            $display("FAIL mid_rerun got lat=%0d cnt=%0d fv=%b idx=%0d exp lat=%0d cnt=1 fv=1 idx=3",
                     lat, cnt, fv, idx, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0, prev = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = 16'hBBBB;
        for (int c = 0; c < 200 && n < 3; c++) begin
            @(negedge clk);
            if (bus.done) begin
                checks++;
                if (bus.match_cnt !== 5'd4 || bus.first_idx !== 4'd3 || bus.first_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_result run=%0d got cnt=%0d idx=%0d fv=%b exp cnt=4 idx=3 fv=1",
                             n, bus.match_cnt, bus.first_idx, bus.first_valid);
                end
                if (n > 0) begin
                    checks++;
                    if (c - prev !== W + 3) begin
                        failures++;
                        $display("FAIL b2b_spacing run=%0d got=%0d exp=%0d", n, c - prev, W + 3);
                    end
                end
                prev = c;
                n++;
                if (n == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL b2b_timeout got dones=%0d exp=3", n);
        end
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
